// File: rtl/operand_stack_pkg.sv
// rtl/operand_stack_pkg.sv - shared trap/value-type codes for the operand stack
//
// Optional build macro: OPERAND_STACK_TYPE_TAG_EN (adds a 2-bit type tag per entry).

package operand_stack_pkg;

    typedef enum logic [2:0] {
        TRAP_NONE      = 3'd0,
        TRAP_OVERFLOW  = 3'd1,
        TRAP_UNDERFLOW = 3'd2,
        TRAP_TYPE      = 3'd3
    } trap_t;

    typedef enum logic [1:0] {
        TYPE_I32 = 2'd0,
        TYPE_I64 = 2'd1,
        TYPE_F32 = 2'd2,
        TYPE_F64 = 2'd3
    } valtype_t;

    // Extra bits carried by every stored entry (tag sits above the value).
`ifdef OPERAND_STACK_TYPE_TAG_EN
    localparam int TAG_BITS = 2;
`else
    localparam int TAG_BITS = 0;
`endif

endpackage

// File: rtl/operand_stack_spill_ram.sv
// rtl/operand_stack_spill_ram.sv - spill storage for stack entries below the top two
//
// Module stack_spill_ram.
// Ports:
//   clk            write clock
//   wr_en/wr_addr/wr_data   single write port (spill index)
//   rd_addr        asynchronous read address (spill index)
//   rd_data        entry at rd_addr (0 when out of range)
//   rd_data_below  entry at rd_addr-1 (0 when rd_addr is 0 or out of range)
// The read port returns a two-entry window so that a double pop can expose
// two spilled entries in the same cycle. Contents are not reset.

module stack_spill_ram #(
    parameter int ENTRIES = 14,
    parameter int EW      = 64,
    localparam int AW     = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [EW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [EW-1:0] rd_data,
    output logic [EW-1:0] rd_data_below
);

    localparam logic [AW-1:0] LAST = AW'(ENTRIES - 1);

    logic [EW-1:0] mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data       = '0;
        rd_data_below = '0;
        if (rd_addr <= LAST) begin
            rd_data = mem[rd_addr];
            if (rd_addr != '0) begin
                rd_data_below = mem[rd_addr - AW'(1)];
            end
        end
    end

endmodule

// File: rtl/operand_stack.sv
// rtl/operand_stack.sv - WebAssembly operand stack with top/next registers and RAM spill
//
// Optional build macro: OPERAND_STACK_TYPE_TAG_EN
//   adds push_type, pop_type, type_check inputs and top_type output.
// Ports:
//   clk, reset (async, active-low)
//   push, push_data, pop_count      operation request (pops apply before push)
//   ready                           no trap latched
//   top, next                       top two entries (0 when absent)
//   count, empty, full              occupancy
//   trap                            0 none, 1 overflow, 2 underflow, 3 type mismatch (sticky)
// Storage: stack index i (0 = bottom) lives in top_q when i = count-1, next_q
// when i = count-2, otherwise in spill RAM at spill index i.

module operand_stack
    import operand_stack_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 16,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic [1:0]       pop_count,
`ifdef OPERAND_STACK_TYPE_TAG_EN
    input  logic [1:0]       push_type,
    input  logic [1:0]       pop_type,
    input  logic             type_check,
    output logic [1:0]       top_type,
`endif
    output logic             ready,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] next,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic [2:0]       trap
);

    localparam int EW    = WIDTH + TAG_BITS;
    localparam int RAM_N = (DEPTH > 2) ? DEPTH - 2 : 1;
    localparam int AW    = (RAM_N > 1) ? $clog2(RAM_N) : 1;

    // ---------------------------------------------------------------- state
    logic [CW-1:0] count_q;
    logic [EW-1:0] top_q;
    logic [EW-1:0] next_q;
    trap_t         trap_q;

    // ------------------------------------------------------------- requests
    logic [CW-1:0] pc_w;
    logic          has_op;
    logic          underflow;
    logic          overflow;
    logic          mismatch;
    logic [CW:0]   after;
    logic [EW-1:0] push_entry;

    assign pc_w      = CW'(pop_count);
    assign has_op    = push | (pop_count != 2'd0);
    assign underflow = (pop_count == 2'd3) || (pc_w > count_q);
    // One extra bit so count+push cannot wrap before the DEPTH comparison.
    assign after     = {1'b0, count_q} - {1'b0, pc_w} + (CW+1)'(push);
    assign overflow  = after > (CW+1)'(DEPTH);

`ifdef OPERAND_STACK_TYPE_TAG_EN
    // Only meaningful once underflow is excluded, so both popped entries exist.
    assign mismatch   = type_check && (pop_count != 2'd0) &&
                        ((top_q[EW-1 -: 2] != pop_type) ||
                         ((pop_count == 2'd2) && (next_q[EW-1 -: 2] != pop_type)));
    assign push_entry = {push_type, push_data};
    assign top_type   = top_q[EW-1 -: 2];
`else
    assign mismatch   = 1'b0;
    assign push_entry = push_data;
`endif

    // ------------------------------------------------------ accept / trap
    trap_t trap_d;
    logic  commit;

    always_comb begin
        trap_d = trap_q;
        commit = 1'b0;
        if ((trap_q == TRAP_NONE) && has_op) begin
            if (underflow) begin
                trap_d = TRAP_UNDERFLOW;
            end else if (mismatch) begin
                trap_d = TRAP_TYPE;
            end else if (overflow) begin
                trap_d = TRAP_OVERFLOW;
            end else begin
                commit = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------ spill RAM
    logic          deep_ok;
    logic [AW-1:0] rd_addr;
    logic [EW-1:0] spill_hi;
    logic [EW-1:0] spill_lo;
    logic          wr_en;
    logic [AW-1:0] wr_addr;

    // Spill window starts at the highest spilled entry (stack index count-3).
    assign deep_ok = count_q >= CW'(3);
    assign rd_addr = AW'(count_q - CW'(3));

    // Only a push without pops moves an entry into RAM: next_q sinks to
    // index count-2. With pops first, the entry below the new next already
    // sits at its spill index.
    assign wr_en   = commit && push && (pop_count == 2'd0) && (count_q >= CW'(2));
    assign wr_addr = AW'(count_q - CW'(2));

    stack_spill_ram #(
        .ENTRIES (RAM_N),
        .EW      (EW)
    ) u_spill (
        .clk           (clk),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (next_q),
        .rd_addr       (rd_addr),
        .rd_data       (spill_hi),
        .rd_data_below (spill_lo)
    );

    // ------------------------------------------------------------ datapath
    logic [EW-1:0] pop_t;   // top after pops, before push
    logic [EW-1:0] pop_u;   // next after pops, before push
    logic [EW-1:0] top_d;
    logic [EW-1:0] next_d;

    always_comb begin
        pop_t = top_q;
        pop_u = next_q;
        case (pop_count)
            2'd1: begin
                pop_t = next_q;
                pop_u = deep_ok ? spill_hi : '0;
            end
            2'd2: begin
                pop_t = deep_ok ? spill_hi : '0;
                pop_u = deep_ok ? spill_lo : '0;
            end
            default: begin
            end
        endcase
        if (push) begin
            top_d  = push_entry;
            next_d = pop_t;
        end else begin
            top_d  = pop_t;
            next_d = pop_u;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            top_q   <= '0;
            next_q  <= '0;
            trap_q  <= TRAP_NONE;
        end else begin
            trap_q <= trap_d;
            if (commit) begin
                count_q <= after[CW-1:0];
                top_q   <= top_d;
                next_q  <= next_d;
            end
        end
    end

    // -------------------------------------------------------------- outputs
    assign ready = (trap_q == TRAP_NONE);
    assign top   = top_q[WIDTH-1:0];
    assign next  = next_q[WIDTH-1:0];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign trap  = trap_q;

endmodule

// File: tb/tb_operand_stack.sv
// tb/tb_operand_stack.sv - scoreboard bench for operand_stack with a queue-based reference model

module tb_operand_stack;

    localparam int D = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        push = 1'b0;
    logic [63:0] push_data = '0;
    logic [1:0]  pop_count = '0;
    logic        ready, empty, full;
    logic [63:0] top, nxt;
    logic [4:0]  count;
    logic [2:0]  trap;
`ifdef OPERAND_STACK_TYPE_TAG_EN
    logic [1:0]  push_type = '0;
    logic [1:0]  pop_type = '0;
    logic        type_check = 1'b0;
    logic [1:0]  top_type;
`endif

    always #5 clk = ~clk;

    operand_stack #(.WIDTH(64), .DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  (push_data),
        .pop_count  (pop_count),
`ifdef OPERAND_STACK_TYPE_TAG_EN
        .push_type  (push_type),
        .pop_type   (pop_type),
        .type_check (type_check),
        .top_type   (top_type),
`endif
        .ready      (ready),
        .top        (top),
        .next       (nxt),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .trap       (trap)
    );

    typedef struct {
        logic [63:0] top;
        logic [63:0] nxt;
        int          cnt;
        int          trp;
        int          ttype;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] m_val[$];
    logic [1:0]  m_tag[$];
    int          m_trap = 0;
    int          total = 0;
    int          bad = 0;

    function automatic exp_t snapshot();
        exp_t e;
        int n = m_val.size();
        e.top   = (n >= 1) ? m_val[n-1] : 64'd0;
        e.nxt   = (n >= 2) ? m_val[n-2] : 64'd0;
        e.cnt   = n;
        e.trp   = m_trap;
        e.ttype = (n >= 1) ? int'(m_tag[n-1]) : 0;
        return e;
    endfunction

    // Reference behaviour: stack as a queue, back = top.
    task automatic model_op(input bit p, input logic [63:0] d, input int pc,
                            input logic [1:0] pt, input bit tc, input logic [1:0] popt);
        int n = m_val.size();
        bit tm = 1'b0;
        if (m_trap != 0 || (!p && pc == 0)) return;
        if (pc == 3 || pc > n) begin
            m_trap = 2;
            return;
        end
`ifdef OPERAND_STACK_TYPE_TAG_EN
        if (tc && pc >= 1)
            tm = (m_tag[n-1] != popt) || (pc == 2 && m_tag[n-2] != popt);
`endif
        if (tm) begin
            m_trap = 3;
        end else if (n - pc + int'(p) > D) begin
            m_trap = 1;
        end else begin
            for (int i = 0; i < pc; i++) begin
                void'(m_val.pop_back());
                void'(m_tag.pop_back());
            end
            if (p) begin
                m_val.push_back(d);
`ifdef OPERAND_STACK_TYPE_TAG_EN
                m_tag.push_back(pt);
`else
                m_tag.push_back(2'd0);
`endif
            end
        end
    endtask

    task automatic step(input bit p, input logic [63:0] d, input int pc,
                        input logic [1:0] pt = 2'd0, input bit tc = 1'b0,
                        input logic [1:0] popt = 2'd0);
        push      = p;
        push_data = d;
        pop_count = pc[1:0];
`ifdef OPERAND_STACK_TYPE_TAG_EN
        push_type  = pt;
        type_check = tc;
        pop_type   = popt;
`endif
        model_op(p, d, pc, pt, tc, popt);
        exp_q.push_back(snapshot());
        @(negedge clk);
    endtask

    task automatic do_reset();
        push      = 1'b0;
        pop_count = 2'd0;
        reset     = 1'b0;
        m_val.delete();
        m_tag.delete();
        m_trap = 0;
        exp_q.push_back(snapshot());
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
        end
    endtask

    // Monitor: every registered update is compared just after the edge.
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("top",   top,                 e.top);
                chk("next",  nxt,                 e.nxt);
                chk("count", 64'(count),          64'(e.cnt));
                chk("trap",  64'(trap),           64'(e.trp));
                chk("ready", 64'(ready),          64'(e.trp == 0));
                chk("empty", 64'(empty),          64'(e.cnt == 0));
                chk("full",  64'(full),           64'(e.cnt == D));
`ifdef OPERAND_STACK_TYPE_TAG_EN
                chk("top_type", 64'(top_type),    64'(e.ttype));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r;
        int pc;
        bit p;
        #2;
        do_reset();

        // single push of an i32 bit pattern
        step(1'b1, 64'h0000_0000_c000_0000, 0);

        // binary-op replace
        do_reset();
        step(1'b1, 64'd1, 0);
        step(1'b1, 64'd2, 0);
        step(1'b1, 64'd3, 0);
        step(1'b1, 64'd5, 2);

        // fill, overflow, ignored pop
        do_reset();
        for (int i = 1; i <= D; i++) step(1'b1, 64'(i), 0);
        step(1'b1, 64'd99, 0);
        step(1'b0, 64'd0, 1);

        // fill, replace on full, then drain one at a time through the spill
        do_reset();
        for (int i = 1; i <= D; i++) step(1'b1, 64'(i), 0);
        step(1'b1, 64'd16, 1);
        for (int i = 0; i < D; i++) step(1'b0, 64'd0, 1);
        step(1'b0, 64'd0, 0);

        // underflow on empty, then mid-stream reset
        step(1'b0, 64'd0, 1);
        step(1'b1, 64'd7, 0);
        do_reset();
        step(1'b1, 64'd8, 0);
        step(1'b1, 64'd9, 0);
        do_reset();

        // double pops that expose two spilled entries
        for (int i = 1; i <= 8; i++) step(1'b1, 64'(i * 11), 0);
        step(1'b0, 64'd0, 2);
        step(1'b0, 64'd0, 2);
        step(1'b0, 64'd0, 3);

`ifdef OPERAND_STACK_TYPE_TAG_EN
        do_reset();
        step(1'b1, 64'h0000_0000_c000_0000, 0, 2'd2);
        step(1'b0, 64'd0, 1, 2'd0, 1'b1, 2'd0);
`endif

        // randomized traffic, pushes favoured so deep states are reached
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (m_trap != 0 && $urandom_range(0, 3) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                r  = $urandom_range(0, 31);
                pc = (r < 12) ? 0 : (r < 22) ? 1 : (r < 31) ? 2 : 3;
                p  = ($urandom_range(0, 3) != 0);
                step(p, {$urandom, $urandom}, pc, 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            end
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
